// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, interior windows out one cycle after the completing pixel.
// No back-pressure; input gaps freeze the window and drop the strobe.
module sobel_window_gen #(
  parameter int PIXEL_WIDTH_OUT = 8,
  parameter int IMG_WIDTH       = 16,
  parameter int IMG_HEIGHT      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] pixel_i,
  input  logic                       pixel_valid_i,
  input  logic                       sof_i,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o [0:8],
  output logic                       window_valid_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_interior;

  logic [PIXEL_WIDTH_OUT-1:0] r_lb1 [0:IMG_WIDTH-1];
  logic [PIXEL_WIDTH_OUT-1:0] r_lb2 [0:IMG_WIDTH-1];
  logic [PIXEL_WIDTH_OUT-1:0] w_lb1_rd;
  logic [PIXEL_WIDTH_OUT-1:0] w_lb2_rd;

  logic [PIXEL_WIDTH_OUT-1:0] r_win [0:8];
  logic                       r_vld;

  // sof forces the accepted pixel to (0,0) whatever the counters say
  always_comb begin
    w_col = sof_i ? '0 : r_col;
    w_row = sof_i ? '0 : r_row;
  end

  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
  end

  always_comb begin
    w_lb1_rd   = r_lb1[w_col];
    w_lb2_rd   = r_lb2[w_col];
    w_interior = (w_row >= RW'(2)) && (w_col >= CW'(2));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid_i) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Line buffers carry no reset: stale contents are masked by the row>=2 gate
  always_ff @(posedge clk_i) begin
    if (pixel_valid_i) begin
      r_lb2[w_col] <= w_lb1_rd;
      r_lb1[w_col] <= pixel_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
      r_vld <= 1'b0;
    end else if (pixel_valid_i) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb2_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb1_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pixel_i;
      r_vld    <= w_interior;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign matrix_pixels_o = r_win;
  assign window_valid_o  = r_vld;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: 4x4 table-driven frames plus a 16x16 random frame.
module tb_sobel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] pix4, pix16;
  logic       vld4, vld16, sof4, sof16;
  logic [7:0] m4  [0:8];
  logic [7:0] m16 [0:8];
  logic       wv4, wv16;

  int total = 0;
  int bad   = 0;

  sobel_window_gen #(.PIXEL_WIDTH_OUT(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .pixel_i(pix4), .pixel_valid_i(vld4), .sof_i(sof4),
    .matrix_pixels_o(m4), .window_valid_o(wv4)
  );

  sobel_window_gen #(.PIXEL_WIDTH_OUT(8), .IMG_WIDTH(16), .IMG_HEIGHT(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .pixel_i(pix16), .pixel_valid_i(vld16), .sof_i(sof16),
    .matrix_pixels_o(m16), .window_valid_o(wv16)
  );

  typedef struct packed {
    logic [7:0]  pix;
    logic        exp_vld;
    logic [71:0] exp_m;
  } vec_t;

  vec_t tbl [16];
  logic [7:0] img [0:15][0:15];

  function automatic logic [71:0] w9(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [71:0] get4();
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = m4[k];
    return r;
  endfunction

  function automatic logic [71:0] get16();
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = m16[k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic send4(input logic [7:0] p, input logic s);
    @(negedge clk);
    pix4 = p; vld4 = 1'b1; sof4 = s;
    @(posedge clk);
    #1;
    vld4 = 1'b0; sof4 = 1'b0;
  endtask

  task automatic send16(input logic [7:0] p, input logic s);
    @(negedge clk);
    pix16 = p; vld16 = 1'b1; sof16 = s;
    @(posedge clk);
    #1;
    vld16 = 1'b0; sof16 = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    vld4 = 1'b0; vld16 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic frame4(input string tag, input logic first_sof, input bit gaps);
    int strobes = 0;
    int ng;
    for (int i = 0; i < 16; i++) begin
      send4(tbl[i].pix, first_sof && (i == 0));
      chk({tag, "_vld"}, {71'd0, wv4}, {71'd0, tbl[i].exp_vld});
      if (wv4) strobes++;
      if (tbl[i].exp_vld) chk({tag, "_win"}, get4(), tbl[i].exp_m);
      else chk({tag, "_m8"}, {64'd0, m4[8]}, {64'd0, tbl[i].pix});
      ng = gaps ? $urandom_range(0, 3) : 0;
      for (int g = 0; g < ng; g++) begin
        idle_cycle();
        chk({tag, "_gap_vld"}, {71'd0, wv4}, 72'd0);
        if (tbl[i].exp_vld) chk({tag, "_gap_win"}, get4(), tbl[i].exp_m);
        else chk({tag, "_gap_m8"}, {64'd0, m4[8]}, {64'd0, tbl[i].pix});
      end
    end
    chk({tag, "_strobes"}, 72'(strobes), 72'd4);
  endtask

  initial begin
    int strobes16;
    logic [71:0] e;
    logic ev;

    for (int i = 0; i < 16; i++) begin
      tbl[i].pix     = 8'(i + 1);
      tbl[i].exp_vld = 1'b0;
      tbl[i].exp_m   = '0;
    end
    tbl[10].exp_vld = 1'b1; tbl[10].exp_m = w9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    tbl[11].exp_vld = 1'b1; tbl[11].exp_m = w9(2, 3, 4, 6, 7, 8, 10, 11, 12);
    tbl[14].exp_vld = 1'b1; tbl[14].exp_m = w9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    tbl[15].exp_vld = 1'b1; tbl[15].exp_m = w9(6, 7, 8, 10, 11, 12, 14, 15, 16);

    rst = 1'b1;
    pix4 = '0; vld4 = 1'b0; sof4 = 1'b0;
    pix16 = '0; vld16 = 1'b0; sof16 = 1'b0;
    #12;
    chk("reset_vld4", {71'd0, wv4}, 72'd0);
    chk("reset_win4", get4(), 72'd0);
    chk("reset_vld16", {71'd0, wv16}, 72'd0);
    chk("reset_win16", get16(), 72'd0);
    @(negedge clk);
    rst = 1'b0;

    frame4("basic", 1'b1, 1'b0);
    frame4("gaps", 1'b1, 1'b1);
    frame4("nosof", 1'b0, 1'b0);

    // Asynchronous reset after pixel 7, asserted between clock edges
    for (int i = 0; i < 7; i++) send4(tbl[i].pix, i == 0);
    chk("prerst_m8", {64'd0, m4[8]}, 72'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_win", get4(), 72'd0);
    chk("midrst_vld", {71'd0, wv4}, 72'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    frame4("post_rst", 1'b0, 1'b0);

    // Partial frame of five pixels, then sof restarts on the sixth
    for (int i = 0; i < 5; i++) send4(8'(100 + i), i == 0);
    frame4("sof_mid", 1'b1, 1'b0);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = 8'($urandom_range(0, 255));
    strobes16 = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        send16(img[r][c], (r == 0) && (c == 0));
        ev = (r >= 2) && (c >= 2);
        chk("f16_vld", {71'd0, wv16}, {71'd0, ev});
        if (wv16) strobes16++;
        if (ev) begin
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              e[(3*rr + cc)*8 +: 8] = img[r-2+rr][c-2+cc];
          chk("f16_win", get16(), e);
        end
        if ($urandom_range(0, 7) == 0) begin
          idle_cycle();
          chk("f16_gap_vld", {71'd0, wv16}, 72'd0);
        end
      end
    end
    chk("f16_strobes", 72'(strobes16), 72'd196);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
